// File: rtl/acorn_ad_stream.sv
// acorn_ad_stream: ACORN-128 v3 associated-data phase with padding, STEPS state updates per clock.
// Optional ACORN_AD_ABORT_EN adds an abort input that drops any run back to IDLE with a cleared state.
module acorn_ad_stream #(
  parameter int AD_W  = 32,
  parameter int LEN_W = 16,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] ad_len,
  input  logic [292:0]     state_in,
  input  logic [AD_W-1:0]  ad_data,
  input  logic             ad_valid,
`ifdef ACORN_AD_ABORT_EN
  input  logic             abort,
`endif
  output logic             ad_ready,
  output logic [292:0]     state_out,
  output logic             busy,
  output logic             done
);
  localparam int BW  = $clog2(AD_W + 1);
  localparam int BPW = AD_W / 8;
  typedef enum logic [2:0] {IDLE, LOAD, PROC, PAD, DONE} fsm_t;
  fsm_t             fsm_q, fsm_d;
  logic [292:0]     st_q, st_d, nxt;
  logic [LEN_W-1:0] bytes_q, bytes_d;
  logic [AD_W-1:0]  buf_q, buf_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic [7:0]       pad_q, pad_d, j;
  logic             ad_ready_q, ad_ready_d, busy_q, busy_d, done_q, done_d, kill;

  function automatic logic [292:0] step(input logic [292:0] s_in, input logic m, input logic ca);
    logic [292:0] s;
    logic ks, f;
    s = s_in;
    s[289] = s[289] ^ s[235] ^ s[230];
    s[230] = s[230] ^ s[196] ^ s[193];
    s[193] = s[193] ^ s[160] ^ s[154];
    s[154] = s[154] ^ s[111] ^ s[107];
    s[107] = s[107] ^ s[66] ^ s[61];
    s[61]  = s[61] ^ s[23] ^ s[0];
    ks = s[12] ^ s[154] ^ (s[235] & s[61]) ^ (s[235] & s[193]) ^ (s[61] & s[193])
       ^ (s[230] & s[111]) ^ (~s[230] & s[66]);
    f  = s[0] ^ ~s[107] ^ (s[244] & s[23]) ^ (s[244] & s[160]) ^ (s[23] & s[160])
       ^ (ca & s[196]) ^ ks;
    return {f ^ m, s[292:1]};
  endfunction

  always_comb begin
    nxt = st_q;
    j   = pad_q;
    // In PAD only the very first pad bit is 1, and ca clears from pad index 128 on
    for (int k = 0; k < STEPS; k++) begin
      j   = pad_q + 8'(k);
      nxt = fsm_q == PAD ? step(nxt, pad_q == 8'd0 && k == 0, ~j[7]) : step(nxt, buf_q[k], 1'b1);
    end
    fsm_d   = fsm_q;
    st_d    = st_q;
    bytes_d = bytes_q;
    buf_d   = buf_q;
    bits_d  = bits_q;
    pad_d   = pad_q;
`ifdef ACORN_AD_ABORT_EN
    kill = abort && fsm_q != IDLE;
`else
    kill = 1'b0;
`endif
    case (fsm_q)
      IDLE: if (start) begin
        st_d    = state_in;
        bytes_d = ad_len;
        fsm_d   = ad_len == '0 ? PAD : LOAD;
      end
      LOAD: if (ad_valid) begin
        buf_d   = ad_data;
        fsm_d   = PROC;
        bits_d  = bytes_q >= LEN_W'(BPW) ? BW'(AD_W) : BW'({bytes_q, 3'b000});
        bytes_d = bytes_q >= LEN_W'(BPW) ? bytes_q - LEN_W'(BPW) : '0;
      end
      PROC: begin
        st_d   = nxt;
        buf_d  = buf_q >> STEPS;
        bits_d = bits_q - BW'(STEPS);
        if (bits_q == BW'(STEPS)) fsm_d = bytes_q == '0 ? PAD : LOAD;
      end
      PAD: begin
        st_d  = nxt;
        pad_d = pad_q + 8'(STEPS);
        if (pad_q == 8'(256 - STEPS)) fsm_d = DONE;
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    if (kill) begin
      fsm_d   = IDLE;
      st_d    = '0;
      bytes_d = '0;
      bits_d  = '0;
      pad_d   = '0;
    end
    ad_ready_d = fsm_d == LOAD;
    busy_d     = fsm_d != IDLE;
    done_d     = fsm_d == DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      st_q       <= '0;
      bytes_q    <= '0;
      buf_q      <= '0;
      bits_q     <= '0;
      pad_q      <= '0;
      ad_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      st_q       <= st_d;
      bytes_q    <= bytes_d;
      buf_q      <= buf_d;
      bits_q     <= bits_d;
      pad_q      <= pad_d;
      ad_ready_q <= ad_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ad_ready  = ad_ready_q;
  assign state_out = st_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_acorn_ad_stream.sv
// tb_acorn_ad_stream: directed checks of the ACORN AD phase against an independent bit-level model.
module tb_acorn_ad_stream;
  logic         clk = 0, rst = 1, start = 0, sel = 0, ad_valid = 0;
  logic [15:0]  ad_len = '0;
  logic [292:0] state_in = '0;
  logic [31:0]  ad_data = '0;
`ifdef ACORN_AD_ABORT_EN
  logic         abort = 0;
`endif
  logic         rdy0, rdy4, busy0, busy4, done0, done4;
  logic [292:0] so0, so4;
  logic         rdy, bsy, dn;
  logic [292:0] sout;
  int           errs = 0, checks = 0;

  always #5 clk = ~clk;

  acorn_ad_stream #(.AD_W(32), .LEN_W(16), .STEPS(1)) u0 (
    .clk(clk), .rst(rst), .start(start & ~sel), .ad_len(ad_len), .state_in(state_in),
    .ad_data(ad_data), .ad_valid(ad_valid),
`ifdef ACORN_AD_ABORT_EN
    .abort(abort),
`endif
    .ad_ready(rdy0), .state_out(so0), .busy(busy0), .done(done0));

  acorn_ad_stream #(.AD_W(32), .LEN_W(16), .STEPS(4)) u4 (
    .clk(clk), .rst(rst), .start(start & sel), .ad_len(ad_len), .state_in(state_in),
    .ad_data(ad_data), .ad_valid(ad_valid),
`ifdef ACORN_AD_ABORT_EN
    .abort(1'b0),
`endif
    .ad_ready(rdy4), .state_out(so4), .busy(busy4), .done(done4));

  assign rdy  = sel ? rdy4 : rdy0;
  assign bsy  = sel ? busy4 : busy0;
  assign dn   = sel ? done4 : done0;
  assign sout = sel ? so4 : so0;

  task automatic chk(input string tag, input logic [292:0] got, input logic [292:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [292:0] upd(input logic [292:0] s_in, input bit m, input bit ca);
    logic [292:0] s;
    bit n289, n230, n193, n154, n107, n61, ks, f;
    s = s_in;
    n289 = s[289] ^ s[235] ^ s[230];
    n230 = s[230] ^ s[196] ^ s[193];
    n193 = s[193] ^ s[160] ^ s[154];
    n154 = s[154] ^ s[111] ^ s[107];
    n107 = s[107] ^ s[66] ^ s[61];
    n61  = s[61] ^ s[23] ^ s[0];
    ks = s[12] ^ n154 ^ ((s[235] & n61) | (s[235] & n193) | (n61 & n193)) ^ (n230 ? s[111] : s[66]);
    f  = s[0] ^ !n107 ^ ((s[244] & s[23]) | (s[244] & s[160]) | (s[23] & s[160])) ^ (ca & s[196]) ^ ks;
    s[289] = n289; s[230] = n230; s[193] = n193; s[154] = n154; s[107] = n107; s[61] = n61;
    return {f ^ m, s[292:1]};
  endfunction

  function automatic logic [292:0] gold(input logic [292:0] s0, input int len, input logic [63:0] d);
    logic [292:0] s;
    s = s0;
    for (int i = 0; i < 8 * len; i++) s = upd(s, d[i], 1'b1);
    for (int p = 0; p < 256; p++) s = upd(s, p == 0, p < 128);
    return s;
  endfunction

  task automatic run(input bit s, input int len, input logic [31:0] w0, input logic [31:0] w1,
                     input int stall, input bit spur, output logic [292:0] res, output int lat,
                     output bit saw_rdy, output bit frozen);
    int wi, st;
    bit acc, got;
    logic [292:0] snap;
    wi = 0; st = stall; got = 0; saw_rdy = 0; frozen = 1; lat = -1; res = '0; snap = '0;
    @(negedge clk);
    sel = s; ad_len = len[15:0]; start = 1; ad_valid = 0;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    for (int c = 1; c <= 2000 && !got; c++) begin
      ad_data  = wi == 0 ? w0 : w1;
      ad_valid = st == 0;
      if (rdy) begin
        saw_rdy = 1;
        if (st > 0) begin
          if (st == stall) snap = sout;
          else if (sout !== snap) frozen = 0;
          st--;
        end
      end
      start = spur && c == 20;
      if (start) ad_len = 16'd0;
      acc = rdy && ad_valid;
      @(posedge clk);
      if (acc) wi++;
      @(negedge clk);
      start = 0;
      if (dn) begin got = 1; lat = c; res = sout; end
    end
    ad_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse_end", {291'd0, dn, bsy}, '0);
  endtask

  logic [292:0] r, r2, r3, si, g;
  int lat;
  bit sr, fz, seen;

  initial begin
    si = 293'({64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
               64'h8796a5b4c3d2e1f0, 64'hdeadbeefcafef00d});
    state_in = si;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", so0, '0);
    chk("reset_flags", {290'd0, rdy0, busy0, done0}, '0);
    rst = 0;

    run(0, 0, 32'h0, 32'h0, 0, 0, r, lat, sr, fz);
    chk("len0_lat", 293'(lat), 293'(256));
    chk("len0_state", r, gold(si, 0, 64'h0));
    chk("len0_no_ready", 293'(sr), 293'(0));

    g = gold(si, 4, 64'h03020100);
    run(0, 4, 32'h03020100, 32'h0, 0, 0, r2, lat, sr, fz);
    chk("len4_lat", 293'(lat), 293'(289));
    chk("len4_state", r2, g);
    chk("hold_in_idle", so0, g);

    run(1, 5, 32'h03020100, 32'hFFFFFF55, 0, 0, r, lat, sr, fz);
    chk("len5_s4_lat", 293'(lat), 293'(76));
    chk("len5_s4_state", r, gold(si, 5, {32'h00000055, 32'h03020100}));
    run(1, 5, 32'h03020100, 32'h12345655, 0, 0, r3, lat, sr, fz);
    chk("len5_upper_ignored", r3, r);

    run(0, 4, 32'h03020100, 32'h0, 10, 0, r, lat, sr, fz);
    chk("stall_lat", 293'(lat), 293'(299));
    chk("stall_state", r, g);
    chk("stall_frozen", 293'(fz), 293'(1));

    run(0, 4, 32'h03020100, 32'h0, 0, 1, r, lat, sr, fz);
    chk("busy_start_lat", 293'(lat), 293'(289));
    chk("busy_start_state", r, g);

    @(negedge clk);
    sel = 0; ad_len = 16'd0; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (100) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_state", so0, '0);
    chk("rst_flags", {291'd0, busy0, done0}, '0);
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done0) seen = 1;
    end
    chk("rst_no_done", 293'(seen), 293'(0));
    run(0, 4, 32'h03020100, 32'h0, 0, 0, r, lat, sr, fz);
    chk("after_rst_state", r, g);

`ifdef ACORN_AD_ABORT_EN
    @(negedge clk);
    sel = 0; ad_len = 16'd4; ad_data = 32'h03020100; ad_valid = 1; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    ad_valid = 0;
    abort = 1;
    start = 1;
    @(negedge clk);
    abort = 0;
    start = 0;
    chk("abort_state", so0, '0);
    chk("abort_flags", {290'd0, rdy0, busy0, done0}, '0);
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done0 || busy0) seen = 1;
    end
    chk("abort_quiet", 293'(seen), 293'(0));
    run(0, 4, 32'h03020100, 32'h0, 0, 0, r, lat, sr, fz);
    chk("after_abort_state", r, g);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
